access_cmd_sequencer: RTL

// - Upstream stage of the generated DUT access port: accepts host commands (nop / write reg / read reg /

---
 rtl/access_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 38 +++
 rtl/access_cmd_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/access_pkg.sv
// access_pkg: opcodes, response status and command record shared by the sequencer and its port
package access_pkg;
    localparam logic [31:0] ACC_OP_NOP    = 32'd0;
    localparam logic [31:0] ACC_OP_WR_REG = 32'd1;
    localparam logic [31:0] ACC_OP_RD_REG = 32'd2;
    localparam logic [31:0] ACC_OP_WR_MEM = 32'd3;
    localparam logic [31:0] ACC_OP_RD_MEM = 32'd4;
    typedef enum logic [1:0] {
        ACC_OK         = 2'd0,
        ACC_BAD_OPCODE = 2'd1,
        ACC_BAD_ID     = 2'd2,
        ACC_BAD_RANGE  = 2'd3
    } acc_status_t;
    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] id;
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] addr;
    } acc_cmd_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with registered full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt, cnt_n;
    assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            cnt <= cnt_n;
            full <= cnt_n == (AW+1)'(DEPTH);
            empty <= cnt_n == '0;
        end
    end
endmodule

// File: rtl/access_cmd_sequencer.sv
// access_cmd_sequencer: buffers host commands, range-checks them, drives the access port and returns tagged responses
module access_cmd_sequencer
    import access_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 8,
    parameter int NUM_REGS   = 2,
    parameter int NUM_MEMS   = 1,
    parameter int MEM_DEPTH  = 16,
    parameter int MAX_MASK   = 1,
    parameter int ACC_LAT    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_opcode,
    input  logic [31:0]      cmd_id,
    input  logic [31:0]      cmd_mask,
    input  logic [31:0]      cmd_data,
    input  logic [31:0]      cmd_addr,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      acc_opcode,
    output logic [31:0]      acc_id,
    output logic [31:0]      acc_mask,
    output logic [31:0]      acc_in,
    output logic [31:0]      acc_addr,
    input  logic [31:0]      acc_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_status,
    output logic             busy
);
    localparam int LW = $clog2(ACC_LAT + 1);
    localparam int FW = $bits(acc_cmd_t) + TAG_W;
    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, RESP} state_t;
    state_t state;
    acc_cmd_t cmd_r;
    logic [TAG_W-1:0] tag_r;
    logic [LW-1:0] lat;
    logic full, empty, push, pop, is_reg, is_mem, is_wr;
    logic [FW-1:0] dout;
    acc_status_t chk;
    assign cmd_ready = ~full;
    assign push = cmd_valid & cmd_ready;
    assign pop = state == IDLE && !empty;
    assign busy = !empty || state != IDLE;
    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din({cmd_opcode, cmd_id, cmd_mask, cmd_data, cmd_addr, cmd_tag}),
        .dout(dout),
        .full(full),
        .empty(empty)
    );
    always_comb begin
        is_reg = cmd_r.opcode == ACC_OP_WR_REG || cmd_r.opcode == ACC_OP_RD_REG;
        is_mem = cmd_r.opcode == ACC_OP_WR_MEM || cmd_r.opcode == ACC_OP_RD_MEM;
        is_wr = cmd_r.opcode == ACC_OP_WR_REG || cmd_r.opcode == ACC_OP_WR_MEM;
        chk = cmd_r.opcode > ACC_OP_RD_MEM ? ACC_BAD_OPCODE :
              (is_reg && cmd_r.id >= 32'(NUM_REGS)) || (is_mem && cmd_r.id >= 32'(NUM_MEMS)) ? ACC_BAD_ID :
              cmd_r.mask >= 32'(MAX_MASK) || (is_mem && cmd_r.addr >= 32'(MEM_DEPTH)) ? ACC_BAD_RANGE :
              ACC_OK;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cmd_r <= '0;
            tag_r <= '0;
            lat <= '0;
            acc_opcode <= '0;
            acc_id <= '0;
            acc_mask <= '0;
            acc_in <= '0;
            acc_addr <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_tag <= '0;
            rsp_status <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    {cmd_r, tag_r} <= dout;
                    state <= CHECK;
                end
                CHECK: begin
                    rsp_tag <= tag_r;
                    lat <= '0;
                    if (chk != ACC_OK) begin
                        rsp_status <= chk;
                        rsp_data <= '0;
                        rsp_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        acc_opcode <= cmd_r.opcode;
                        acc_id <= cmd_r.id;
                        acc_mask <= cmd_r.mask;
                        acc_in <= cmd_r.data;
                        acc_addr <= cmd_r.addr;
                        state <= ISSUE;
                    end
                end
                ISSUE: if (lat == LW'(ACC_LAT - 1)) begin
                    rsp_status <= ACC_OK;
                    rsp_data <= is_wr ? '0 : acc_out;
                    rsp_valid <= 1'b1;
                    acc_opcode <= '0;
                    acc_id <= '0;
                    acc_mask <= '0;
                    acc_in <= '0;
                    acc_addr <= '0;
                    state <= RESP;
                end else begin
                    lat <= lat + LW'(1);
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
